// File: rtl/mem_req_arbiter.sv
// Two-client round-robin arbiter serialising single-word requests onto the AXI bridge port.
// Optional build macro MEM_ARB_TIMEOUT_EN aborts a stalled BUSY transaction after TIMEOUT_CYCLES.
module mem_req_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req_i,
    input  logic              c0_we_i,
    input  logic [ADDR_W-1:0] c0_addr_i,
    input  logic [DATA_W-1:0] c0_wdata_i,
    output logic [DATA_W-1:0] c0_rdata_o,
    output logic              c0_ready_o,
    output logic              c0_err_o,
    input  logic              c1_req_i,
    input  logic              c1_we_i,
    input  logic [ADDR_W-1:0] c1_addr_i,
    input  logic [DATA_W-1:0] c1_wdata_i,
    output logic [DATA_W-1:0] c1_rdata_o,
    output logic              c1_ready_o,
    output logic              c1_err_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    logic   last_grant;
    logic   grant;
    logic   any_req;
    logic   pick;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] busy_cnt;
    logic             c0_err_q;
    logic             c1_err_q;

    assign c0_err_o = c0_err_q;
    assign c1_err_o = c1_err_q;
`else
    assign c0_err_o = 1'b0;
    assign c1_err_o = 1'b0;
`endif

    // On a tie the client that did not win last time goes next.
    always_comb begin
        any_req = c0_req_i | c1_req_i;
        if (c0_req_i && c1_req_i) begin
            pick = ~last_grant;
        end else begin
            pick = c1_req_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            mem_ce_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            c0_rdata_o <= '0;
            c1_rdata_o <= '0;
            c0_ready_o <= 1'b0;
            c1_ready_o <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            busy_cnt   <= '0;
            c0_err_q   <= 1'b0;
            c1_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= pick;
                        mem_ce_o   <= 1'b1;
                        mem_we_o   <= pick ? c1_we_i : c0_we_i;
                        mem_addr_o <= pick ? c1_addr_i : c0_addr_i;
                        mem_data_o <= pick ? c1_wdata_i : c0_wdata_i;
`ifdef MEM_ARB_TIMEOUT_EN
                        busy_cnt   <= '0;
`endif
                        state      <= BUSY;
                    end
                end

                BUSY: begin
                    // A bridge completion in the timeout cycle still counts as a normal finish.
                    if (mem_ready_i) begin
                        if (!mem_we_o) begin
                            if (grant) begin
                                c1_rdata_o <= mem_data_i;
                            end else begin
                                c0_rdata_o <= mem_data_i;
                            end
                        end
                        mem_ce_o   <= 1'b0;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= '0;
                        mem_data_o <= '0;
                        c0_ready_o <= ~grant;
                        c1_ready_o <= grant;
                        state      <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (busy_cnt == CNT_LAST) begin
                        if (grant) begin
                            c1_rdata_o <= '0;
                            c1_err_q   <= 1'b1;
                        end else begin
                            c0_rdata_o <= '0;
                            c0_err_q   <= 1'b1;
                        end
                        mem_ce_o   <= 1'b0;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= '0;
                        mem_data_o <= '0;
                        c0_ready_o <= ~grant;
                        c1_ready_o <= grant;
                        state      <= DONE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    c0_ready_o <= 1'b0;
                    c1_ready_o <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    c0_err_q   <= 1'b0;
                    c1_err_q   <= 1'b0;
`endif
                    last_grant <= grant;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter; define MEM_ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_mem_req_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif

    logic        clk;
    logic        rst;
    logic        c0_req, c0_we, c1_req, c1_we;
    logic [31:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
    logic [31:0] c0_rdata, c1_rdata;
    logic        c0_ready, c0_err, c1_ready, c1_err;
    logic        mem_ce, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_data, mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_req_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .c0_req_i(c0_req),
        .c0_we_i(c0_we),
        .c0_addr_i(c0_addr),
        .c0_wdata_i(c0_wdata),
        .c0_rdata_o(c0_rdata),
        .c0_ready_o(c0_ready),
        .c0_err_o(c0_err),
        .c1_req_i(c1_req),
        .c1_we_i(c1_we),
        .c1_addr_i(c1_addr),
        .c1_wdata_i(c1_wdata),
        .c1_rdata_o(c1_rdata),
        .c1_ready_o(c1_ready),
        .c1_err_o(c1_err),
        .mem_ce_o(mem_ce),
        .mem_we_o(mem_we),
        .mem_addr_o(mem_addr),
        .mem_data_o(mem_data),
        .mem_data_i(mem_rdata),
        .mem_ready_i(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int client, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (client == 0) begin
            c0_req = req; c0_we = we; c0_addr = addr; c0_wdata = wdata;
        end else begin
            c1_req = req; c1_we = we; c1_addr = addr; c1_wdata = wdata;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); tick();

        checkOutput("rst_mem_ce", {31'b0, mem_ce}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_c0_ready", {31'b0, c0_ready}, 32'd0);
        checkOutput("rst_c0_rdata", c0_rdata, 32'h0);
        checkOutput("rst_c1_rdata", c1_rdata, 32'h0);
        checkOutput("rst_c0_err", {31'b0, c0_err}, 32'd0);
        rst = 1'b1;

        // c0 read of 0x100, bridge answers in the third BUSY cycle
        applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        checkOutput("rd_mem_ce", {31'b0, mem_ce}, 32'd1);
        checkOutput("rd_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rd_mem_addr", mem_addr, 32'h100);
        tick();
        checkOutput("rd_hold_ce", {31'b0, mem_ce}, 32'd1);
        tick();
        checkOutput("rd_hold_addr", mem_addr, 32'h100);
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rd_c0_ready", {31'b0, c0_ready}, 32'd1);
        checkOutput("rd_c0_rdata", c0_rdata, 32'hDEADBEEF);
        checkOutput("rd_c1_ready", {31'b0, c1_ready}, 32'd0);
        checkOutput("rd_done_ce", {31'b0, mem_ce}, 32'd0);
        checkOutput("rd_done_addr", mem_addr, 32'h0);
        tick();
        checkOutput("rd_pulse_end", {31'b0, c0_ready}, 32'd0);
        checkOutput("rd_gap1_ce", {31'b0, mem_ce}, 32'd0);
        checkOutput("rd_rdata_keep", c0_rdata, 32'hDEADBEEF);
        tick();
        checkOutput("rd_gap2_ce", {31'b0, mem_ce}, 32'd0);

        // c1 write; read data from the bridge must not be captured
        applyStimulus(1, 1'b1, 1'b1, 32'h20, 32'h12345678);
        tick();
        checkOutput("wr_mem_ce", {31'b0, mem_ce}, 32'd1);
        checkOutput("wr_mem_we", {31'b0, mem_we}, 32'd1);
        checkOutput("wr_mem_addr", mem_addr, 32'h20);
        checkOutput("wr_mem_data", mem_data, 32'h12345678);
        tick();
        checkOutput("wr_hold_data", mem_data, 32'h12345678);
        mem_ready = 1'b1; mem_rdata = 32'hAAAA5555;
        tick();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("wr_c1_ready", {31'b0, c1_ready}, 32'd1);
        checkOutput("wr_c0_ready", {31'b0, c0_ready}, 32'd0);
        checkOutput("wr_c1_rdata", c1_rdata, 32'h0);
        checkOutput("wr_c0_rdata", c0_rdata, 32'hDEADBEEF);
        checkOutput("wr_done_we", {31'b0, mem_we}, 32'd0);
        tick();

        // bridge ready while IDLE is ignored
        mem_ready = 1'b1; mem_rdata = 32'h55555555;
        tick();
        checkOutput("idle_rdy_c0", {31'b0, c0_ready}, 32'd0);
        checkOutput("idle_rdy_c1", {31'b0, c1_ready}, 32'd0);
        checkOutput("idle_rdy_ce", {31'b0, mem_ce}, 32'd0);
        mem_ready = 1'b0; mem_rdata = 32'h0;
        tick();
        checkOutput("idle_rdy_c1_rdata", c1_rdata, 32'h0);

        // both clients held from reset: c0, c1, c0, c1
        rst = 1'b0;
        tick();
        rst = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h80, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("rr%0d_addr", k), mem_addr, (k % 2 == 0) ? 32'h40 : 32'h80);
            mem_ready = 1'b1; mem_rdata = 32'h1000 + k;
            tick();
            mem_ready = 1'b0; mem_rdata = 32'h0;
            checkOutput($sformatf("rr%0d_c0_ready", k), {31'b0, c0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr%0d_c1_ready", k), {31'b0, c1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k % 2 == 0) begin
                checkOutput($sformatf("rr%0d_rdata", k), c0_rdata, 32'h1000 + k);
            end else begin
                checkOutput($sformatf("rr%0d_rdata", k), c1_rdata, 32'h1000 + k);
            end
            tick();
        end
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("rr_end_c0_rdata", c0_rdata, 32'h1002);

`ifdef MEM_ARB_TIMEOUT_EN
        // bridge never answers: abort after 8 BUSY cycles
        applyStimulus(0, 1'b1, 1'b0, 32'h300, 32'h0);
        tick();
        checkOutput("tmo_ce_first", {31'b0, mem_ce}, 32'd1);
        for (int k = 1; k < 8; k++) begin
            tick();
            checkOutput($sformatf("tmo_ce_%0d", k), {31'b0, mem_ce}, 32'd1);
        end
        tick();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("tmo_ce_drop", {31'b0, mem_ce}, 32'd0);
        checkOutput("tmo_c0_ready", {31'b0, c0_ready}, 32'd1);
        checkOutput("tmo_c0_err", {31'b0, c0_err}, 32'd1);
        checkOutput("tmo_c0_rdata", c0_rdata, 32'h0);
        tick();
        checkOutput("tmo_err_clear", {31'b0, c0_err}, 32'd0);
        checkOutput("tmo_ready_clear", {31'b0, c0_ready}, 32'd0);
        tick();
`endif

        // reset during BUSY aborts the transaction silently
        applyStimulus(0, 1'b1, 1'b1, 32'h55, 32'h77);
        tick();
        checkOutput("rb_busy_ce", {31'b0, mem_ce}, 32'd1);
        rst = 1'b0;
        tick();
        checkOutput("rb_ce", {31'b0, mem_ce}, 32'd0);
        checkOutput("rb_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rb_addr", mem_addr, 32'h0);
        checkOutput("rb_data", mem_data, 32'h0);
        checkOutput("rb_c1_rdata", c1_rdata, 32'h0);
        checkOutput("rb_c0_rdata", c0_rdata, 32'h0);
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        checkOutput("rb_late_c0_ready", {31'b0, c0_ready}, 32'd0);
        checkOutput("rb_late_c1_ready", {31'b0, c1_ready}, 32'd0);
        tick();
        checkOutput("rb_late_c0_rdata", c0_rdata, 32'h0);
        checkOutput("rb_late_ce", {31'b0, mem_ce}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
